// File: rtl/spw_pkg.sv
// SpaceWire transmit encodings, character lengths and character frame builders.
// A frame holds the line bits of one character (or a whole NULL), bit 0 first on the line.
package spw_pkg;

    localparam int unsigned FRAME_W  = 10;
    localparam int unsigned LEN_W    = 4;
    localparam int unsigned DATA_LEN = 10;
    localparam int unsigned CTRL_LEN = 4;
    localparam int unsigned NULL_LEN = 8;

    localparam logic [1:0] SPW_FCT = 2'b00;
    localparam logic [1:0] SPW_EOP = 2'b01;
    localparam logic [1:0] SPW_EEP = 2'b10;
    localparam logic [1:0] SPW_ESC = 2'b11;

    localparam logic [1:0] TYPE_DATA = 2'b00;
    localparam logic [1:0] TYPE_EOP  = 2'b01;
    localparam logic [1:0] TYPE_EEP  = 2'b10;
    localparam logic [1:0] TYPE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } tx_state_e;

    typedef struct packed {
        logic [FRAME_W-1:0] bits;
        logic [LEN_W-1:0]   len;
        logic               par;   // xor of the data/control bits, seeds the next P
    } tx_frame_t;

    // Odd parity over prev bits + P + flag: control P = prev xor, data P = its inverse.
    function automatic tx_frame_t ctrl_frame(input logic par_prev, input logic [1:0] code);
        tx_frame_t f;
        f.bits = {6'b000000, code, 1'b1, par_prev};
        f.len  = LEN_W'(CTRL_LEN);
        f.par  = ^code;
        return f;
    endfunction

    function automatic tx_frame_t data_frame(input logic par_prev, input logic [7:0] data);
        tx_frame_t f;
        f.bits = {data, 1'b0, ~par_prev};
        f.len  = LEN_W'(DATA_LEN);
        f.par  = ^data;
        return f;
    endfunction

    // ESC then FCT; ESC's control bits have even weight so the FCT half always has P=0.
    function automatic tx_frame_t null_frame(input logic par_prev);
        tx_frame_t f;
        f.bits = {2'b00, SPW_FCT, 1'b1, 1'b0, SPW_ESC, 1'b1, par_prev};
        f.len  = LEN_W'(NULL_LEN);
        f.par  = 1'b0;
        return f;
    endfunction

endpackage

// File: rtl/spw_bit_tick.sv
// Bit-period down-counter: one tick per bit period of div+1 clocks.
// The divisor is taken from the port only on the tick that starts a new character.
module spw_bit_tick #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             load_st,
    input  logic [DIV_W-1:0] div,
    output logic             tick_c
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;

    assign tick_c = run && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        div_d = div_q;
        if (!run) begin
            cnt_d = '0;
        end else if (tick_c) begin
            if (load_st) begin
                div_d = div;
                cnt_d = div;
            end else begin
                cnt_d = div_q;
            end
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            div_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/spw_ds_tx.sv
// SpaceWire transmit encoder: FCT/N-char/NULL selection, odd parity, and data-strobe line driver.
module spw_ds_tx
    import spw_pkg::*;
#(
    parameter int unsigned DIV_W   = 8,
    parameter int unsigned FCT_MAX = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_type,
    input  logic [7:0]       in_data,
    input  logic             fct_req,
    output logic             fct_ack,
    output logic             fct_full,
    output logic             tx_d,
    output logic             tx_s
);

    localparam int unsigned FCT_W = $clog2(FCT_MAX + 1);

    tx_state_e          state_q, state_d;
    logic [FCT_W-1:0]   fct_cnt_q, fct_cnt_d;
    logic [FRAME_W-1:0] sh_q, sh_d;
    logic [LEN_W-1:0]   left_q, left_d;
    logic               par_q, par_d;
    logic               tx_d_q, tx_d_d;
    logic               tx_s_q, tx_s_d;
    logic               in_ready_q, in_ready_d;
    logic               fct_ack_q, fct_ack_d;
    logic               fct_full_q, fct_full_d;

    logic               run_c;
    logic               tick_c;
    logic               boundary_c;
    logic               shift_tick_c;
    logic               fct_sel_c;
    tx_frame_t          frame_c;

    assign run_c        = en && (state_q != ST_IDLE);
    assign boundary_c   = tick_c && (state_q == ST_LOAD);
    assign shift_tick_c = tick_c && (state_q == ST_SHIFT);

    spw_bit_tick #(
        .DIV_W (DIV_W)
    ) u_bit_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run_c),
        .load_st (state_q == ST_LOAD),
        .div     (div),
        .tick_c  (tick_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // LOAD holds the last bit of the previous character until the tick that starts the next one.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_LOAD;
                ST_LOAD:  if (tick_c) state_d = ST_SHIFT;
                ST_SHIFT: if (tick_c && (left_q == LEN_W'(1))) state_d = ST_LOAD;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Character selection: pending FCT, then offered N-char, else NULL.
    always_comb begin
        fct_sel_c = (fct_cnt_q != '0);
        if (fct_sel_c) begin
            frame_c = ctrl_frame(par_q, SPW_FCT);
        end else if (in_valid) begin
            case (in_type)
                TYPE_DATA:           frame_c = data_frame(par_q, in_data);
                TYPE_EOP:            frame_c = ctrl_frame(par_q, SPW_EOP);
                TYPE_EEP, TYPE_RSVD: frame_c = ctrl_frame(par_q, SPW_EEP);
            endcase
        end else begin
            frame_c = null_frame(par_q);
        end
    end

    always_comb begin
        sh_d       = sh_q;
        left_d     = left_q;
        par_d      = par_q;
        tx_d_d     = tx_d_q;
        tx_s_d     = tx_s_q;
        fct_cnt_d  = fct_cnt_q;
        fct_ack_d  = boundary_c && fct_sel_c;
        in_ready_d = boundary_c && !fct_sel_c && in_valid;

        if (!en) begin
            sh_d   = '0;
            left_d = '0;
            par_d  = 1'b0;
            tx_d_d = 1'b0;
            tx_s_d = 1'b0;
        end else if (boundary_c) begin
            tx_d_d = frame_c.bits[0];
            sh_d   = frame_c.bits >> 1;
            left_d = frame_c.len - LEN_W'(1);
            par_d  = frame_c.par;
        end else if (shift_tick_c) begin
            tx_d_d = sh_q[0];
            sh_d   = sh_q >> 1;
            left_d = left_q - LEN_W'(1);
        end
        // Strobe flips whenever data does not, so d^s toggles once per bit.
        if (boundary_c || shift_tick_c) begin
            tx_s_d = tx_d_d ^ ~(tx_d_q ^ tx_s_q);
        end

        if (fct_ack_d && !fct_req) begin
            fct_cnt_d = fct_cnt_q - FCT_W'(1);
        end else if (fct_req && !fct_ack_d && (fct_cnt_q != FCT_W'(FCT_MAX))) begin
            fct_cnt_d = fct_cnt_q + FCT_W'(1);
        end
        fct_full_d = (fct_cnt_d == FCT_W'(FCT_MAX));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fct_cnt_q  <= '0;
            sh_q       <= '0;
            left_q     <= '0;
            par_q      <= 1'b0;
            tx_d_q     <= 1'b0;
            tx_s_q     <= 1'b0;
            in_ready_q <= 1'b0;
            fct_ack_q  <= 1'b0;
            fct_full_q <= 1'b0;
        end else begin
            fct_cnt_q  <= fct_cnt_d;
            sh_q       <= sh_d;
            left_q     <= left_d;
            par_q      <= par_d;
            tx_d_q     <= tx_d_d;
            tx_s_q     <= tx_s_d;
            in_ready_q <= in_ready_d;
            fct_ack_q  <= fct_ack_d;
            fct_full_q <= fct_full_d;
        end
    end

    assign tx_d     = tx_d_q;
    assign tx_s     = tx_s_q;
    assign in_ready = in_ready_q;
    assign fct_ack  = fct_ack_q;
    assign fct_full = fct_full_q;

endmodule

// File: tb/tb_spw_ds_tx.sv
// Bench for spw_ds_tx: bit-queue reference model checked every cycle, plus hand-computed
// line patterns for NULL, data, FCT bursts, enable drop and divisor changes.
module tb_spw_ds_tx;

    localparam int FCT_LIMIT = 7;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] div;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_type;
    logic [7:0] in_data;
    logic       fct_req;
    logic       fct_ack;
    logic       fct_full;
    logic       tx_d;
    logic       tx_s;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    spw_ds_tx #(
        .DIV_W   (8),
        .FCT_MAX (7)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .div      (div),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_type  (in_type),
        .in_data  (in_data),
        .fct_req  (fct_req),
        .fct_ack  (fct_ack),
        .fct_full (fct_full),
        .tx_d     (tx_d),
        .tx_s     (tx_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: line bits of the current character held in a queue.
    logic m_on       = 1'b0;
    int   m_wait     = 0;
    int   m_div      = 0;
    logic m_bits[$];
    int   m_prev_ones = 0;
    int   m_fct      = 0;
    logic m_en_edge  = 1'b0;
    logic e_d = 1'b0, e_s = 1'b0, e_rdy = 1'b0, e_ack = 1'b0, e_full = 1'b0;

    // Observed line bits, the cycle each appeared, and where in_ready/fct_ack pulsed.
    logic cap[$];
    int   cap_t[$];
    int   rdy_mark[$];
    int   ack_mark[$];
    logic prev_x = 1'b0;

    task automatic push_char(input logic flag, input logic [7:0] payload, input int nbits);
        int   ones;
        logic p;
        ones = 0;
        for (int i = 0; i < nbits; i++) if (payload[i]) ones++;
        p = (((m_prev_ones + int'(flag)) % 2) == 0);
        m_bits.push_back(p);
        m_bits.push_back(flag);
        for (int i = 0; i < nbits; i++) m_bits.push_back(payload[i]);
        m_prev_ones = ones;
    endtask

    task automatic model_step();
        logic nb;
        logic taken;
        e_rdy = 1'b0;
        e_ack = 1'b0;
        taken = 1'b0;
        if (!rst_n) begin
            m_on = 1'b0; m_wait = 0; m_bits.delete(); m_prev_ones = 0; m_fct = 0;
            m_en_edge = 1'b0;
            e_d = 1'b0; e_s = 1'b0; e_full = 1'b0;
            return;
        end
        m_en_edge = en;
        if (!en) begin
            m_on = 1'b0; m_wait = 0; m_bits.delete(); m_prev_ones = 0;
            e_d = 1'b0; e_s = 1'b0;
        end else if (!m_on) begin
            m_on = 1'b1;
        end else if (m_wait > 0) begin
            m_wait--;
        end else begin
            if (m_bits.size() == 0) begin
                if (m_fct > 0) begin
                    push_char(1'b1, 8'h00, 2);
                    m_fct--;
                    taken = 1'b1;
                    e_ack = 1'b1;
                end else if (in_valid) begin
                    case (in_type)
                        2'b00:   push_char(1'b0, in_data, 8);
                        2'b01:   push_char(1'b1, 8'h01, 2);
                        default: push_char(1'b1, 8'h02, 2);
                    endcase
                    e_rdy = 1'b1;
                end else begin
                    push_char(1'b1, 8'h03, 2);
                    push_char(1'b1, 8'h00, 2);
                end
                m_div = int'(div);
            end
            nb     = m_bits.pop_front();
            e_s    = nb ^ ~(e_d ^ e_s);
            e_d    = nb;
            m_wait = m_div;
        end
        if (fct_req) begin
            if (taken) m_fct++;
            else if (m_fct < FCT_LIMIT) m_fct++;
        end
        e_full = (m_fct == FCT_LIMIT);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_val(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int q_at(input int q[$], input int i);
        if (i < 0 || i >= q.size()) return -1000;
        return q[i];
    endfunction

    // pat lists the line bits first-to-last from bit n-1 down to bit 0.
    task automatic check_bits(input string name, input int start, input logic [15:0] pat, input int n);
        logic [15:0] act;
        act = '0;
        if (start < 0 || start + n > cap.size()) begin
            checks++;
            errors++;
            $display("FAIL %s: %0d bits captured, need %0d from index %0d", name, cap.size(), n, start);
            return;
        end
        for (int i = 0; i < n; i++) act[n-1-i] = cap[start+i];
        check_val(name, longint'(act), longint'(pat));
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (rdy_mark.size() < target && n < budget) begin
            tick();
            n++;
        end
        check_val(name, longint'(rdy_mark.size()), longint'(target));
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        cyc++;
        check_bit("tx_d", tx_d, e_d);
        check_bit("tx_s", tx_s, e_s);
        check_bit("in_ready", in_ready, e_rdy);
        check_bit("fct_ack", fct_ack, e_ack);
        check_bit("fct_full", fct_full, e_full);
        if (m_en_edge && ((tx_d ^ tx_s) !== prev_x)) begin
            cap.push_back(tx_d);
            cap_t.push_back(cyc);
        end
        prev_x = tx_d ^ tx_s;
        if (in_ready === 1'b1) rdy_mark.push_back(cap.size() - 1);
        if (fct_ack === 1'b1) ack_mark.push_back(cap.size() - 1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, r1, a0, c0, en_cyc;
        rst_n = 1'b0; en = 1'b1; div = 8'd0; in_valid = 1'b0;
        in_type = 2'b00; in_data = 8'h00; fct_req = 1'b0;

        // Reset held with enable high: line and handshakes stay low.
        repeat (5) tick();
        check_val("reset_outputs", longint'({tx_d, tx_s, in_ready, fct_ack, fct_full}), 0);

        // Idle NULLs at one bit per clock.
        rst_n = 1'b1;
        repeat (20) tick();
        check_bits("null_0", 0, 16'b01110100, 8);
        check_bits("null_1", 8, 16'b01110100, 8);
        check_val("null_rate", q_at(cap_t, 15) - q_at(cap_t, 0), 15);

        // 0x5A after a NULL: P=1, then ESC with prev weight 4 -> P=0.
        in_valid = 1'b1; in_type = 2'b00; in_data = 8'h5A;
        wait_ready("rdy_5a", 1, 40);
        in_valid = 1'b0;
        repeat (20) tick();
        r0 = q_at(rdy_mark, 0);
        check_bits("data_5a", r0, 16'b1001011010, 10);
        check_bits("esc_after_5a", r0 + 10, 16'b0111, 4);

        // Three FCT requests during 0xC3 overtake the pending 0x81.
        in_valid = 1'b1; in_data = 8'hC3;
        wait_ready("rdy_c3", 2, 40);
        in_data = 8'h81;
        fct_req = 1'b1;
        repeat (3) tick();
        fct_req = 1'b0;
        wait_ready("rdy_81", 3, 60);
        in_valid = 1'b0;
        repeat (14) tick();
        r1 = q_at(rdy_mark, 1);
        check_bits("data_c3", r1, 16'b1011000011, 10);
        check_bits("fct_x3", r1 + 10, 16'b010001000100, 12);
        check_bits("data_81", r1 + 22, 16'b1010000001, 10);
        check_val("rdy_81_pos", q_at(rdy_mark, 2), r1 + 22);
        check_val("fct_ack_x3", ack_mark.size(), 3);

        // Eight requests while disabled saturate at seven.
        en = 1'b0;
        tick();
        fct_req = 1'b1;
        repeat (8) tick();
        fct_req = 1'b0;
        tick();
        check_val("fct_full_en0", fct_full, 1);
        check_val("model_fct7", m_fct, 7);
        a0 = ack_mark.size();
        en = 1'b1;
        repeat (60) tick();
        check_val("fct_burst", ack_mark.size() - a0, 7);
        check_bits("fct_first_en", q_at(ack_mark, a0), 16'b0100, 4);
        check_val("fct_full_after", fct_full, 0);

        // Drop enable mid data character at div=3.
        div = 8'd3;
        in_valid = 1'b1; in_data = 8'hFF;
        wait_ready("rdy_ff", 4, 100);
        in_valid = 1'b0;
        repeat (8) tick();
        en = 1'b0;
        tick();
        check_val("line_off", longint'({tx_d, tx_s}), 0);
        repeat (6) tick();
        check_val("rdy_total", rdy_mark.size(), 4);

        // Re-enable: parity history cleared; div change lands at the next character.
        c0 = cap.size();
        en = 1'b1;
        en_cyc = cyc;
        repeat (6) tick();
        div = 8'd1;
        repeat (60) tick();
        check_bits("esc_reenable", c0, 16'b0111, 4);
        check_val("first_bit_lat", q_at(cap_t, c0) - en_cyc, 2);
        check_val("period_old_div", q_at(cap_t, c0 + 1) - q_at(cap_t, c0), 4);
        check_val("period_new_div", q_at(cap_t, c0 + 9) - q_at(cap_t, c0 + 8), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
